// File: rtl/regfile_write_bank.sv
// Write side of the register file: one-hot address decode, 31 writable
// registers (register 0 reads as zero), sticky written flags and a distinct-write count.
module regfile_write_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_enable,
    input  logic [4:0]             write_address,
    input  logic [WIDTH-1:0]       write_data,
    output logic [DEPTH-1:0]       decoded,
    output logic [WIDTH*DEPTH-1:0] reg_flat,
    output logic [DEPTH-1:0]       written,
    output logic [5:0]             write_count
);

    localparam logic [5:0] COUNT_MAX = 6'(DEPTH - 1);

    logic [5:0] count_q;
    logic [5:0] count_d;
    logic       first_write;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        // AND form keeps decoded at 0 even if the address is unknown while disabled.
        assign decoded[gi] = write_enable & (write_address == 5'(gi));

        if (gi == 0) begin : g_zero
            assign reg_flat[WIDTH-1:0] = '0;
            assign written[0]          = 1'b0;
        end else begin : g_store
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
            logic             flag_q;
            logic             flag_d;

            always_comb begin
                data_d = data_q;
                flag_d = flag_q;
                if (decoded[gi]) begin
                    data_d = write_data;
                    flag_d = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                    flag_q <= 1'b0;
                end else begin
                    data_q <= data_d;
                    flag_q <= flag_d;
                end
            end

            assign reg_flat[WIDTH*gi +: WIDTH] = data_q;
            assign written[gi]                 = flag_q;
        end
    end

    // A write counts only when it lands on a nonzero register not yet written.
    assign first_write = |(decoded[DEPTH-1:1] & ~written[DEPTH-1:1]);

    always_comb begin
        count_d = count_q;
        if (first_write && (count_q != COUNT_MAX)) begin
            count_d = count_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign write_count = count_q;

endmodule

// File: tb/tb_regfile_write_bank.sv
// Bench for regfile_write_bank: directed writes checked against an array model
// every cycle, plus literal expectations at key points.
module tb_regfile_write_bank;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          write_enable = 1'b0;
    logic [4:0]    write_address = 5'd0;
    logic [31:0]   write_data = 32'd0;
    logic [31:0]   decoded;
    logic [1023:0] reg_flat;
    logic [31:0]   written;
    logic [5:0]    write_count;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model: plain array of register contents plus set of written indices.
    logic [31:0] m_regs [32];
    logic [31:0] m_written;

    regfile_write_bank #(.WIDTH(32), .DEPTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .decoded       (decoded),
        .reg_flat      (reg_flat),
        .written       (written),
        .write_count   (write_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_written <= 32'd0;
        end else if (write_enable && write_address != 5'd0) begin
            m_regs[write_address]    <= write_data;
            m_written[write_address] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_decoded();
        logic [31:0] one;
        one = 32'd1;
        return write_enable ? (one << write_address) : 32'd0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reg(input string name, input int idx, input logic [31:0] exp);
        check($sformatf("%s reg%0d", name, idx), 64'(reg_flat[32*idx +: 32]), 64'(exp));
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (started) begin
            int bad;
            bad = -1;
            for (int i = 31; i >= 0; i--)
                if (reg_flat[32*i +: 32] !== m_regs[i]) bad = i;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL model reg_flat reg%0d: got %h expected %h at %0t",
                         bad, reg_flat[32*bad +: 32], m_regs[bad], $time);
            end
            check("model decoded", 64'(decoded), 64'(exp_decoded()));
            check("model written", 64'(written), 64'(m_written));
            check("model write_count", 64'(write_count), 64'($countones(m_written)));
        end
    end

    // Called just after a rising edge; the write commits on the next one.
    task automatic write_cycle(input logic [4:0] a, input logic [31:0] d);
        write_enable  = 1'b1;
        write_address = a;
        write_data    = d;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        #1;
        reset   = 1'b1;
        started = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset reg_flat", 64'(|reg_flat), 64'd0);
        check("reset written", 64'(written), 64'd0);
        check("reset write_count", 64'(write_count), 64'd0);
        check("reset decoded", 64'(decoded), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic write
        write_enable  = 1'b1;
        write_address = 5'd5;
        write_data    = 32'hDEADBEEF;
        #1;
        check("basic decoded", 64'(decoded), 64'h0000_0020);
        check("basic no bypass", 64'(reg_flat[191:160]), 64'd0);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("basic reg5", 64'(reg_flat[191:160]), 64'hDEADBEEF);
        check("basic written", 64'(written), 64'h0000_0020);
        check("basic count", 64'(write_count), 64'd1);
        check("basic others", 64'(|{reg_flat[1023:192], reg_flat[159:0]}), 64'd0);

        // Unknown address while disabled
        write_address = 5'bxxxxx;
        write_data    = 32'h1234_5678;
        #1;
        check("x addr decoded", 64'(decoded), 64'd0);
        @(posedge clk);
        #1;
        check("x addr written", 64'(written), 64'h0000_0020);

        // Zero register
        write_enable  = 1'b1;
        write_address = 5'd0;
        write_data    = 32'hFFFF_FFFF;
        #1;
        check("zero decoded", 64'(decoded), 64'h0000_0001);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check("zero reg0", 64'(reg_flat[31:0]), 64'd0);
        check("zero written0", 64'(written[0]), 64'd0);
        check("zero count", 64'(write_count), 64'd1);

        // Overwrite and count, from a clean state
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        write_cycle(5'd7, 32'd1);
        write_cycle(5'd7, 32'd2);
        write_cycle(5'd31, 32'd3);
        check_reg("ovw", 7, 32'd2);
        check_reg("ovw", 31, 32'd3);
        check("ovw count", 64'(write_count), 64'd2);
        check("ovw written", 64'(written), 64'h8000_0080);

        // Fill all
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 1; i < 32; i++) write_cycle(5'(i), 32'(i));
        for (int i = 0; i < 32; i++) check_reg("fill", i, 32'(i));
        check("fill written", 64'(written), 64'hFFFF_FFFE);
        check("fill count", 64'(write_count), 64'd31);
        write_cycle(5'd12, 32'hABCD_0012);
        check("refill count", 64'(write_count), 64'd31);
        check_reg("refill", 12, 32'hABCD_0012);

        // Async reset between edges during an active write
        write_enable  = 1'b1;
        write_address = 5'd3;
        write_data    = 32'h0000_0333;
        #2;
        reset = 1'b1;
        #1;
        check("async reg_flat", 64'(|reg_flat), 64'd0);
        check("async written", 64'(written), 64'd0);
        check("async count", 64'(write_count), 64'd0);
        @(posedge clk);
        #1;
        check("async hold reg3", 64'(reg_flat[127:96]), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        check_reg("release", 3, 32'h0000_0333);
        check("release count", 64'(write_count), 64'd1);
        check("release written", 64'(written), 64'h0000_0008);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
